fdl_code_ctrl: RTL
==================

// Module: fdl_code_ctrl
// PURPOSE
//  Generates the 6-bit thermometer load code Q that drives the fine delay line (FDL).
//  Consumes phase-detector up/down decisions and steps the fine code one load per update.
//  Hands over to the coarse delay line via a 4-phase req/ack handshake on fine overflow/underflow.
//  Reports lock once the loop dithers around a stable point.
// PARAMETERS
//  N_TAP        6  number of FDL load cells = width of Q; fine level L in 0..N_TAP
//  SETTLE       4  cycles spent in SETTLE between updates (>=1); update period = SETTLE+1
//  LOCK_TOGGLES 4  consecutive direction reversals required to assert locked (>=1)
// PORTS
//  clk_in      in   1      reference clock; all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      loop enable; 0 = freeze code
//  pd_up       in   1      phase detector: more delay needed (sync to clk_in)
//  pd_dn       in   1      phase detector: less delay needed (sync to clk_in)
//  coarse_ack  in   1      coarse controller acknowledge (sync to clk_in)
//  Q           out  N_TAP  thermometer code to FDL; Q = (1<<L)-1, registered
//  coarse_inc  out  1      request: coarse delay +1 step
//  coarse_dec  out  1      request: coarse delay -1 step
//  locked      out  1      fine loop locked indication
// BEHAVIOUR
//  Reset (async, rst_n=0): L=N_TAP/2 (Q=6'b000111), coarse_inc=0, coarse_dec=0, locked=0,
//   reversal count=0, last direction=none, state=IDLE. All outputs registered, no comb paths.
//  States: IDLE, SETTLE, SAMPLE, HS_REQ, HS_REL.
//  IDLE: Q held. en=1 -> SETTLE with cnt=SETTLE-1.
//  SETTLE: cnt decrements each cycle; when cnt==0 -> SAMPLE. en=0 -> IDLE.
//  SAMPLE (1 cycle): en=0 -> IDLE, no step. Else decision:
//   up&!dn, L<N_TAP -> L+1;  up&!dn, L==N_TAP -> coarse_inc=1, HS_REQ
//   dn&!up, L>0     -> L-1;  dn&!up, L==0     -> coarse_dec=1, HS_REQ
//   both or neither -> hold L, lock state untouched
//   Non-handshake outcomes -> SETTLE (cnt=SETTLE-1). Q updates on the edge leaving SAMPLE.
//  HS_REQ: req held until coarse_ack=1 sampled; that edge: req->0, L->0 (after inc) or
//   L->N_TAP (after dec), -> HS_REL. Only one of coarse_inc/coarse_dec ever high.
//  HS_REL: wait coarse_ack=0, then -> SETTLE (en=1) or IDLE (en=0).
//  en is ignored during HS_REQ/HS_REL; handshake always completes.
//  Lock: a step opposite to the previous step increments the reversal count (saturating);
//   count==LOCK_TOGGLES -> locked=1. A step in the same direction as the previous step
//   clears the count and locked. Any coarse handshake or en=0 clears count, last direction
//   and locked. First step after a clear sets direction, count stays 0.
//  Latency: en rise -> first Q change SETTLE+2 edges later (SETTLE + SAMPLE + register).
//  Reset mid-handshake: reqs drop immediately; coarse controller must tolerate abandoned req.
// TESTING
//  1 reset: rst_n=0 -> Q=000111, coarse_inc=coarse_dec=0, locked=0, regardless of inputs.
//  2 en=1, pd_up=1 held: Q 001111,011111,111111 at 5-cycle spacing; next sample
//    coarse_inc=1; coarse_ack high 3 cycles later -> coarse_inc=0, Q=000000 next edge.
//  3 Q=000000, pd_dn=1: coarse_dec=1, ack -> Q=111111; ack held high -> stays HS_REL.
//  4 alternate pd_up/pd_dn each update from Q=000111: locked=1 after 4th reversal;
//    then two pd_up updates -> locked=0 on second.
//  5 pd_up=pd_dn=1 and both 0 for 10 updates -> Q unchanged, locked unchanged.
//  6 en=0 during SETTLE -> IDLE, Q frozen, locked=0; en=0 during HS_REQ -> handshake finishes.

Source files
------------

// File: rtl/fdl_code_ctrl.sv
// fdl_code_ctrl: steps the fine delay line thermometer code from phase-detector decisions,
// hands over to the coarse line on overflow/underflow and flags lock on sustained dithering.
module fdl_code_ctrl #(
    parameter int N_TAP        = 6,
    parameter int SETTLE       = 4,
    parameter int LOCK_TOGGLES = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pd_up,
    input  logic             pd_dn,
    input  logic             coarse_ack,
    output logic [N_TAP-1:0] Q,
    output logic             coarse_inc,
    output logic             coarse_dec,
    output logic             locked
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int RW = $clog2(LOCK_TOGGLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HS_REQ, S_HS_REL} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

    state_t        state;
    dir_t          last_dir;
    dir_t          dir;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rev;
    logic          up_only;
    logic          dn_only;
    logic          sampling;
    logic          step_up;
    logic          step_dn;
    logic          hs_start;
    logic          clr;

    // The code is a thermometer, so its end bits tell whether the fine range is exhausted.
    always_comb begin
        up_only  = pd_up & ~pd_dn;
        dn_only  = pd_dn & ~pd_up;
        sampling = (state == S_SAMPLE) & en;
        step_up  = sampling & up_only & ~Q[N_TAP-1];
        step_dn  = sampling & dn_only & Q[0];
        hs_start = sampling & ((up_only & Q[N_TAP-1]) | (dn_only & ~Q[0]));
        clr      = hs_start | (~en & (state != S_HS_REQ) & (state != S_HS_REL));
        dir      = step_up ? D_UP : D_DN;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            Q          <= N_TAP'((1 << (N_TAP / 2)) - 1);
            coarse_inc <= 1'b0;
            coarse_dec <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_SETTLE;
                        cnt   <= CW'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (!en) state <= S_IDLE;
                    else if (cnt == '0) state <= S_SAMPLE;
                    else cnt <= cnt - CW'(1);
                end
                S_SAMPLE: begin
                    state      <= !en ? S_IDLE : hs_start ? S_HS_REQ : S_SETTLE;
                    cnt        <= CW'(SETTLE - 1);
                    coarse_inc <= hs_start & up_only;
                    coarse_dec <= hs_start & dn_only;
                    if (step_up) Q <= {Q[N_TAP-2:0], 1'b1};
                    if (step_dn) Q <= {1'b0, Q[N_TAP-1:1]};
                end
                S_HS_REQ: begin
                    if (coarse_ack) begin
                        Q          <= coarse_inc ? '0 : '1;
                        coarse_inc <= 1'b0;
                        coarse_dec <= 1'b0;
                        state      <= S_HS_REL;
                    end
                end
                S_HS_REL: begin
                    if (!coarse_ack) begin
                        state <= en ? S_SETTLE : S_IDLE;
                        cnt   <= CW'(SETTLE - 1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A step against the previous direction counts as one reversal; a repeat resets the run.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            last_dir <= D_NONE;
            rev      <= '0;
            locked   <= 1'b0;
        end else if (clr) begin
            last_dir <= D_NONE;
            rev      <= '0;
            locked   <= 1'b0;
        end else if (step_up | step_dn) begin
            last_dir <= dir;
            rev      <= (last_dir == D_NONE || last_dir == dir) ? '0 :
                        (rev == RW'(LOCK_TOGGLES)) ? rev : rev + RW'(1);
            locked   <= (last_dir != D_NONE) && (last_dir != dir) &&
                        (rev >= RW'(LOCK_TOGGLES - 1));
        end
    end
endmodule
